// File: rtl/ex_muldiv_stage.sv
// Execute stage with EX/MEM register: single-cycle logic/shift/arith plus an
// iterative 16-step multiply/divide engine enabled by the EX_MULDIV_EN macro.
module ex_muldiv_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [2:0]        ex_aluop,
    input  logic [2:0]        ex_alusel,
    input  logic [DATA_W-1:0] ex_reg0,
    input  logic [DATA_W-1:0] ex_reg1,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic              ex_we,
    output logic              stall_req,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_we
);

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;

    logic [3:0]        shamt;
    logic [DATA_W-1:0] alu_res;

    assign shamt = ex_reg1[3:0];

    always_comb begin
        alu_res = '0;
        case (ex_alusel)
            SEL_LOGIC: begin
                case (ex_aluop)
                    3'd0:    alu_res = ex_reg0 & ex_reg1;
                    3'd1:    alu_res = ex_reg0 | ex_reg1;
                    3'd2:    alu_res = ex_reg0 ^ ex_reg1;
                    3'd3:    alu_res = ~ex_reg0;
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (ex_aluop)
                    3'd0:    alu_res = ex_reg0 << shamt;
                    3'd1:    alu_res = ex_reg0 >> shamt;
                    3'd2:    alu_res = $signed(ex_reg0) >>> shamt;
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (ex_aluop)
                    3'd0:    alu_res = ex_reg0 + ex_reg1;
                    3'd1:    alu_res = ex_reg0 - ex_reg1;
                    3'd2:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(ex_reg0) < $signed(ex_reg1))};
                    3'd3:    alu_res = {{(DATA_W-1){1'b0}}, (ex_reg0 < ex_reg1)};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam logic [2:0] SEL_MULDIV = 3'd4;
    localparam int         CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [2:0]        aluop;
        logic [ADDR_W-1:0] waddr;
        logic              we;
    } op_t;

    state_t            state;
    op_t               op;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hi, lo, opb;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_sh;
    logic              div_ge;
    logic [DATA_W-1:0] div_diff;
    logic [DATA_W-1:0] md_res;

    // {hi,lo} is the product accumulator for multiply and {remainder,quotient} for divide
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign div_sh   = {hi, lo[DATA_W-1]};
    assign div_ge   = div_sh >= {1'b0, opb};
    assign div_diff = div_sh[DATA_W-1:0] - opb;

    always_comb begin
        case (op.aluop)
            3'd0, 3'd2: md_res = lo;
            3'd1, 3'd3: md_res = hi;
            default:    md_res = '0;
        endcase
    end

    assign stall_req = !rst && ((state == IDLE && ex_alusel == SEL_MULDIV) || state == CALC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opb       <= '0;
            mem_wdata <= '0;
            mem_waddr <= '0;
            mem_we    <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_wdata <= '0;
            mem_waddr <= '0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_alusel == SEL_MULDIV) begin
                        op        <= '{aluop: ex_aluop, waddr: ex_waddr, we: ex_we};
                        hi        <= '0;
                        lo        <= ex_reg0;
                        opb       <= ex_reg1;
                        cnt       <= '0;
                        state     <= CALC;
                        mem_wdata <= '0;
                        mem_waddr <= '0;
                        mem_we    <= 1'b0;
                    end else begin
                        mem_wdata <= alu_res;
                        mem_waddr <= ex_waddr;
                        mem_we    <= ex_we;
                    end
                end
                CALC: begin
                    if (op.aluop[1]) begin
                        hi <= div_ge ? div_diff : div_sh[DATA_W-1:0];
                        lo <= {lo[DATA_W-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[DATA_W:1];
                        lo <= {mul_sum[0], lo[DATA_W-1:1]};
                    end
                    mem_wdata <= '0;
                    mem_waddr <= '0;
                    mem_we    <= 1'b0;
                    if (cnt == CNT_LAST) state <= DONE;
                    else                 cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    // ex_* still holds the finished op here; it must not restart
                    mem_wdata <= md_res;
                    mem_waddr <= op.waddr;
                    mem_we    <= op.we;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign stall_req = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wdata <= '0;
            mem_waddr <= '0;
            mem_we    <= 1'b0;
        end else if (flush) begin
            mem_wdata <= '0;
            mem_waddr <= '0;
            mem_we    <= 1'b0;
        end else begin
            mem_wdata <= alu_res;
            mem_waddr <= ex_waddr;
            mem_we    <= ex_we;
        end
    end
`endif

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed spec cases plus random ops against an
// arithmetic reference model; MULDIV checks follow the EX_MULDIV_EN macro.
module tb_ex_muldiv_stage;
    localparam int DW = 16;
    localparam int AW = 4;
`ifdef EX_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [2:0]    ex_aluop = '0;
    logic [2:0]    ex_alusel = '0;
    logic [DW-1:0] ex_reg0 = '0;
    logic [DW-1:0] ex_reg1 = '0;
    logic [AW-1:0] ex_waddr = '0;
    logic          ex_we = 1'b0;
    logic          stall_req;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_waddr;
    logic          mem_we;

    int vecs = 0;
    int errs = 0;

    ex_muldiv_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg0(ex_reg0), .ex_reg1(ex_reg1),
        .ex_waddr(ex_waddr), .ex_we(ex_we),
        .stall_req(stall_req),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the operation definitions
    function automatic logic [15:0] ref_res(input logic [2:0] sel, input logic [2:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        int          amt;
        amt = int'(b[3:0]);
        p   = 32'(a) * 32'(b);
        ref_res = 16'h0;
        case (sel)
            3'd1: case (op)
                3'd0: ref_res = a & b;
                3'd1: ref_res = a | b;
                3'd2: ref_res = a ^ b;
                3'd3: ref_res = ~a;
                default: ref_res = 16'h0;
            endcase
            3'd2: case (op)
                3'd0: ref_res = 16'(32'(a) * (32'd1 << amt));
                3'd1: ref_res = 16'(32'(a) / (32'd1 << amt));
                3'd2: ref_res = a[15] ? ~((~a) >> amt) : (a >> amt);
                default: ref_res = 16'h0;
            endcase
            3'd3: case (op)
                3'd0: ref_res = 16'(32'(a) + 32'(b));
                3'd1: ref_res = 16'(32'h10000 + 32'(a) - 32'(b));
                3'd2: ref_res = ((a ^ 16'h8000) < (b ^ 16'h8000)) ? 16'd1 : 16'd0;
                3'd3: ref_res = (a < b) ? 16'd1 : 16'd0;
                default: ref_res = 16'h0;
            endcase
            3'd4: if (MD) case (op)
                3'd0: ref_res = p[15:0];
                3'd1: ref_res = p[31:16];
                3'd2: ref_res = (b == 0) ? 16'hFFFF : a / b;
                3'd3: ref_res = (b == 0) ? a : a % b;
                default: ref_res = 16'h0;
            endcase
            default: ref_res = 16'h0;
        endcase
    endfunction

    task automatic run_single(input logic [2:0] sel, input logic [2:0] op,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] wa, input logic we, input string tag);
        ex_alusel = sel; ex_aluop = op; ex_reg0 = a; ex_reg1 = b; ex_waddr = wa; ex_we = we;
        #1;
        chk({tag, "/stall"}, 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/wdata"}, 32'(mem_wdata), 32'(ref_res(sel, op, a, b)));
        chk({tag, "/waddr"}, 32'(mem_waddr), 32'(wa));
        chk({tag, "/we"}, 32'(mem_we), 32'(we));
    endtask

    task automatic run_muldiv(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] wa, input logic we, input string tag);
        int n;
        ex_alusel = 3'd4; ex_aluop = op; ex_reg0 = a; ex_reg1 = b; ex_waddr = wa; ex_we = we;
        #1;
        chk({tag, "/stall0"}, 32'(stall_req), 32'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk({tag, "/bubble"}, {15'd0, mem_we, mem_wdata}, 32'd0);
            if (!stall_req) break;
            n++;
        end
        chk({tag, "/stall_cycles"}, 32'(n), 32'd17);
        @(posedge clk); #1;
        chk({tag, "/wdata"}, 32'(mem_wdata), 32'(ref_res(3'd4, op, a, b)));
        chk({tag, "/waddr"}, 32'(mem_waddr), 32'(wa));
        chk({tag, "/we"}, 32'(mem_we), 32'(we));
    endtask

    initial begin
        logic [2:0]  s, o;
        logic [15:0] a, b;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/wdata", 32'(mem_wdata), 32'd0);
        chk("rst/waddr", 32'(mem_waddr), 32'd0);
        chk("rst/we", 32'(mem_we), 32'd0);
        chk("rst/stall", 32'(stall_req), 32'd0);
        rst = 1'b0;

        run_single(3'd3, 3'd0, 16'd2, 16'd2, 4'd1, 1'b1, "add");
        chk("add/const", 32'(mem_wdata), 32'd4);
        run_single(3'd2, 3'd2, 16'h8000, 16'd3, 4'd2, 1'b1, "sra");
        chk("sra/const", 32'(mem_wdata), 32'hF000);
        run_single(3'd3, 3'd2, 16'hFFFF, 16'd1, 4'd3, 1'b1, "slt");
        chk("slt/const", 32'(mem_wdata), 32'd1);
        run_single(3'd3, 3'd3, 16'hFFFF, 16'd1, 4'd4, 1'b1, "sltu");
        chk("sltu/const", 32'(mem_wdata), 32'd0);
        run_single(3'd1, 3'd3, 16'h0F0F, 16'h1234, 4'd5, 1'b0, "not");
        run_single(3'd0, 3'd0, 16'h1111, 16'h2222, 4'd6, 1'b1, "nop");
        run_single(3'd6, 3'd1, 16'h1111, 16'h2222, 4'd7, 1'b1, "undef_sel");

        // asynchronous reset clears a live result without a clock edge
        run_single(3'd3, 3'd1, 16'd9, 16'd4, 4'd9, 1'b1, "sub");
        #2 rst = 1'b1;
        #1;
        chk("arst/wdata", 32'(mem_wdata), 32'd0);
        chk("arst/waddr", 32'(mem_waddr), 32'd0);
        chk("arst/we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        #1;

`ifdef EX_MULDIV_EN
        run_muldiv(3'd0, 16'd300, 16'd300, 4'd1, 1'b1, "mul");
        chk("mul/const", 32'(mem_wdata), 32'h5F90);
        run_muldiv(3'd1, 16'd300, 16'd300, 4'd2, 1'b1, "mulh");
        chk("mulh/const", 32'(mem_wdata), 32'd1);
        run_muldiv(3'd2, 16'd100, 16'd7, 4'd3, 1'b1, "divu");
        chk("divu/const", 32'(mem_wdata), 32'd14);
        run_muldiv(3'd3, 16'd100, 16'd7, 4'd4, 1'b1, "remu");
        chk("remu/const", 32'(mem_wdata), 32'd2);
        run_muldiv(3'd2, 16'd5, 16'd0, 4'd5, 1'b1, "divu0");
        chk("divu0/const", 32'(mem_wdata), 32'hFFFF);
        run_muldiv(3'd3, 16'd5, 16'd0, 4'd6, 1'b1, "remu0");
        chk("remu0/const", 32'(mem_wdata), 32'd5);

        // flush on the 8th CALC cycle
        ex_alusel = 3'd4; ex_aluop = 3'd0; ex_reg0 = 16'd1234; ex_reg1 = 16'd77;
        ex_waddr = 4'd3; ex_we = 1'b1;
        #1;
        repeat (8) @(posedge clk);
        #1;
        flush = 1'b1;
        ex_alusel = 3'd3; ex_aluop = 3'd0; ex_reg0 = 16'd10; ex_reg1 = 16'd20;
        ex_waddr = 4'd5; ex_we = 1'b1;
        #1;
        chk("flush/stall_before", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush/stall_after", 32'(stall_req), 32'd0);
        chk("flush/we", 32'(mem_we), 32'd0);
        run_single(3'd3, 3'd0, 16'd10, 16'd20, 4'd5, 1'b1, "post_flush_add");

        // reset in the middle of CALC
        ex_alusel = 3'd4; ex_aluop = 3'd2; ex_reg0 = 16'd999; ex_reg1 = 16'd13;
        ex_waddr = 4'd8; ex_we = 1'b1;
        #1;
        repeat (5) @(posedge clk);
        #1;
        chk("rstcalc/stall_before", 32'(stall_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstcalc/stall", 32'(stall_req), 32'd0);
        chk("rstcalc/mem", {11'd0, mem_we, mem_waddr, mem_wdata}, 32'd0);
        ex_alusel = 3'd0;
        rst = 1'b0;
        #1;
        run_single(3'd3, 3'd0, 16'd40, 16'd2, 4'd2, 1'b1, "post_rst_add");
`else
        run_single(3'd4, 3'd0, 16'd3, 16'd5, 4'd1, 1'b1, "md_off");
        chk("md_off/const", 32'(mem_wdata), 32'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            s = 3'($urandom_range(0, 7));
            o = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (s == 3'd4 && MD)
                run_muldiv(o & 3'd3, a, b, 4'($urandom), 1'($urandom), "rnd_md");
            else
                run_single(s, o, a, b, 4'($urandom), 1'($urandom), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
